// File: rtl/kmac_msg_blocker.sv
// kmac_msg_blocker
//   Packs the KMAC message byte stream into RATE_BYTES-wide blocks for the
//   cSHAKE absorb stage. On message end it appends right_encode(OUT_LEN_BITS)
//   and the cSHAKE pad10*1 padding, then emits the final block with blk_last.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   msg_valid/ready   byte-stream handshake; msg_data byte, msg_last ends the
//                     message, msg_empty marks a zero-length message (data ignored)
//   blk_valid/ready   block handshake; blk_data byte i at [8i+7:8i]
//   blk_last          block is the padded final block
//   busy              message in flight (first accepted beat .. final block taken)
module kmac_msg_blocker #(
  parameter int RATE_BYTES   = 136,
  parameter int OUT_LEN_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    msg_valid,
  output logic                    msg_ready,
  input  logic [7:0]              msg_data,
  input  logic                    msg_last,
  input  logic                    msg_empty,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [8*RATE_BYTES-1:0] blk_data,
  output logic                    blk_last,
  output logic                    busy
);
  localparam int            CW      = $clog2(RATE_BYTES + 1);
  localparam logic [CW-1:0] FULL    = CW'(RATE_BYTES);
  localparam logic [CW-1:0] LASTIDX = CW'(RATE_BYTES - 1);
  localparam logic [15:0]   LEN     = 16'(OUT_LEN_BITS);

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_APPEND, S_PAD} state_t;

  state_t                  r_state, w_state_nxt;
  state_t                  r_ret, w_ret_nxt;     // where EMIT goes after the handshake
  logic [CW-1:0]           r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [1:0]              r_idx, w_idx_nxt;     // right_encode byte index
  logic                    r_last, w_last_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_init;               // delays msg_ready one cycle after reset
  logic [8*RATE_BYTES-1:0] r_buf;
  logic                    w_wr, w_pad_hi, w_clr;
  logic [7:0]              w_wr_byte;

  assign w_cnt_inc = r_cnt + CW'(1);
  assign blk_data  = r_buf;
  assign blk_last  = r_last;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_ret   <= S_FILL;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_init  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
      r_init  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_busy_nxt  = r_busy;
    w_wr        = 1'b0;
    w_wr_byte   = 8'h00;
    w_pad_hi    = 1'b0;
    w_clr       = 1'b0;
    msg_ready   = 1'b0;
    blk_valid   = 1'b0;
    case (r_state)
      S_FILL: begin
        msg_ready = r_init;
        if (msg_valid && r_init) begin
          w_busy_nxt = 1'b1;
          if (!msg_empty) begin
            w_wr      = 1'b1;
            w_wr_byte = msg_data;
            w_cnt_nxt = w_cnt_inc;
          end
          if (msg_last) w_idx_nxt = 2'd0;
          if (!msg_empty && w_cnt_inc == FULL) begin
            // Full block goes out first; a pending message end resumes in APPEND.
            w_state_nxt = S_EMIT;
            w_last_nxt  = 1'b0;
            w_ret_nxt   = msg_last ? S_APPEND : S_FILL;
          end else if (msg_last) begin
            w_state_nxt = S_APPEND;
          end
        end
      end
      S_APPEND: begin
        w_wr      = 1'b1;
        w_cnt_nxt = w_cnt_inc;
        w_idx_nxt = r_idx + 2'd1;
        case (r_idx)
          2'd0:    w_wr_byte = LEN[15:8];
          2'd1:    w_wr_byte = LEN[7:0];
          default: w_wr_byte = 8'h02;
        endcase
        if (w_cnt_inc == FULL) begin
          w_state_nxt = S_EMIT;
          w_last_nxt  = 1'b0;
          if (r_idx == 2'd2) w_ret_nxt = S_PAD;
          else               w_ret_nxt = S_APPEND;
        end else if (r_idx == 2'd2) begin
          w_state_nxt = S_PAD;
        end
      end
      S_PAD: begin
        // 0x04 = cSHAKE domain bits 00 + first pad bit; 0x80 = final pad bit.
        w_wr        = 1'b1;
        w_wr_byte   = (r_cnt == LASTIDX) ? 8'h84 : 8'h04;
        w_pad_hi    = (r_cnt != LASTIDX);
        w_last_nxt  = 1'b1;
        w_ret_nxt   = S_FILL;
        w_state_nxt = S_EMIT;
      end
      default: begin // S_EMIT
        blk_valid = 1'b1;
        if (blk_ready) begin
          w_clr       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = r_ret;
          if (r_last) begin
            w_last_nxt = 1'b0;
            w_busy_nxt = 1'b0;
          end
        end
      end
    endcase
  end

  // Block buffer: cleared on every block handshake so padding zeros come free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
    end else if (w_clr) begin
      r_buf <= '0;
    end else begin
      for (int i = 0; i < RATE_BYTES; i++)
        if (w_wr && r_cnt == CW'(i)) r_buf[8*i +: 8] <= w_wr_byte;
      if (w_pad_hi) r_buf[8*RATE_BYTES-1 -: 8] <= 8'h80;
    end
  end

endmodule

// File: tb/tb_kmac_msg_blocker.sv
module tb_kmac_msg_blocker;
  localparam int R      = 136;
  localparam int L      = 256;
  localparam int BUDGET = 4000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic msg_valid = 1'b0, msg_last = 1'b0, msg_empty = 1'b0, blk_ready = 1'b0;
  logic [7:0] msg_data = 8'h00;
  logic msg_ready, blk_valid, blk_last, busy;
  logic [8*R-1:0] blk_data;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  byte unsigned txq[$];
  bit tx_empty;
  logic [8*R-1:0] rx_q[$], exp_q[$];
  bit rx_lq[$], exp_lq[$];
  bit rx_to, tx_to, rx_busy0;
  int rx_first_cyc, tx_last_cyc;

  kmac_msg_blocker #(.RATE_BYTES(R), .OUT_LEN_BITS(L)) dut (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data(msg_data), .msg_last(msg_last), .msg_empty(msg_empty),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_last(blk_last), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: message ++ right_encode(L) ++ pad10*1, sliced into rate blocks.
  function automatic void build_exp();
    byte unsigned s[$];
    logic [8*R-1:0] b;
    int nblk;
    s = txq;
    s.push_back(8'(L >> 8)); s.push_back(8'(L & 255)); s.push_back(8'h02);
    if (s.size() % R == R - 1) s.push_back(8'h84);
    else begin
      s.push_back(8'h04);
      while (s.size() % R != R - 1) s.push_back(8'h00);
      s.push_back(8'h80);
    end
    exp_q.delete(); exp_lq.delete();
    nblk = s.size() / R;
    for (int k = 0; k < nblk; k++) begin
      b = '0;
      for (int j = 0; j < R; j++) b[8*j +: 8] = s[k*R + j];
      exp_q.push_back(b); exp_lq.push_back(k == nblk - 1);
    end
  endfunction

  function automatic int diff_byte(input logic [8*R-1:0] a, input logic [8*R-1:0] b);
    for (int j = 0; j < R; j++) if (a[8*j +: 8] !== b[8*j +: 8]) return j;
    return 0;
  endfunction

  function automatic logic [8*R-1:0] abc_block();
    logic [8*R-1:0] b;
    b = '0;
    b[63:0] = 64'h0004_0200_0163_6261;
    b[8*(R-1) +: 8] = 8'h80;
    return b;
  endfunction

  task automatic set_msg(input int len, input int fill);
    txq.delete();
    tx_empty = (len == 0);
    for (int k = 0; k < len; k++) txq.push_back(fill < 0 ? 8'($urandom) : 8'(fill));
  endtask

  task automatic send(input int vld_pct);
    int nb, i, c;
    bit hs;
    nb = tx_empty ? 1 : txq.size();
    i = 0; c = 0; hs = 0; tx_to = 0;
    while (i < nb) begin
      @(negedge clk); c++;
      if (hs) begin
        i++;
        if (i == nb) tx_last_cyc = cyc;
      end
      if (i == nb) break;
      if (c > BUDGET) begin tx_to = 1; break; end
      if (!msg_valid || hs) begin
        if ($urandom_range(99) < vld_pct) begin
          msg_valid = 1; msg_last = (i == nb - 1); msg_empty = tx_empty;
          msg_data  = tx_empty ? 8'($urandom) : txq[i];
        end else begin
          msg_valid = 0; msg_last = 0; msg_empty = 0; msg_data = 8'($urandom);
        end
      end
      hs = msg_valid && msg_ready;
    end
    msg_valid = 0; msg_last = 0; msg_empty = 0;
  endtask

  task automatic recv(input int rdy_pct);
    int c;
    bit seen;
    c = 0; seen = 0; rx_to = 0;
    rx_q.delete(); rx_lq.delete();
    forever begin
      @(negedge clk); c++;
      if (c > BUDGET) begin rx_to = 1; break; end
      blk_ready = ($urandom_range(99) < rdy_pct);
      if (blk_valid && !seen) begin seen = 1; rx_first_cyc = cyc; rx_busy0 = busy; end
      if (blk_valid && blk_ready) begin
        rx_q.push_back(blk_data); rx_lq.push_back(blk_last);
        if (blk_last) break;
      end
    end
    @(negedge clk); blk_ready = 0;
  endtask

  task automatic run_msg(input int vld_pct, input int rdy_pct);
    build_exp();
    fork
      send(vld_pct);
      recv(rdy_pct);
    join
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (msg_ready !== 1'b0) begin n_err++; $display("FAIL rst_msg_ready got %b want 0", msg_ready); end
    n_chk++; if (blk_valid !== 1'b0) begin n_err++; $display("FAIL rst_blk_valid got %b want 0", blk_valid); end
    n_chk++; if (blk_last !== 1'b0) begin n_err++; $display("FAIL rst_blk_last got %b want 0", blk_last); end
    n_chk++; if (blk_data !== '0) begin n_err++; $display("FAIL rst_blk_data nonzero byte %0d", diff_byte(blk_data, '0)); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    rst_n = 1;
    #1;
    n_chk++; if (msg_ready !== 1'b0) begin n_err++; $display("FAIL rel_ready_early got %b want 0", msg_ready); end
    @(negedge clk);
    n_chk++; if (msg_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready_rise got %b want 1", msg_ready); end
  endtask

  task automatic test_abc();
    set_msg(0, 0);
    txq = '{8'h61, 8'h62, 8'h63}; tx_empty = 0;
    run_msg(100, 100);
    n_chk++; if (tx_to || rx_to) begin n_err++; $display("FAIL abc_timeout tx=%0b rx=%0b want 0", tx_to, rx_to); end
    n_chk++; if (rx_q.size() !== 1) begin n_err++; $display("FAIL abc_nblk got %0d want 1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      n_chk++; if (rx_q[0] !== abc_block()) begin n_err++;
        $display("FAIL abc_data byte %0d got %h want %h", diff_byte(rx_q[0], abc_block()),
                 rx_q[0][8*diff_byte(rx_q[0], abc_block()) +: 8], abc_block()[8*diff_byte(rx_q[0], abc_block()) +: 8]); end
      n_chk++; if (rx_lq[0] !== 1'b1) begin n_err++; $display("FAIL abc_last got %b want 1", rx_lq[0]); end
    end
    n_chk++; if (rx_first_cyc - tx_last_cyc !== 4) begin n_err++; $display("FAIL abc_latency got %0d want 4", rx_first_cyc - tx_last_cyc); end
    n_chk++; if (rx_busy0 !== 1'b1) begin n_err++; $display("FAIL abc_busy_mid got %b want 1", rx_busy0); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL abc_busy_end got %b want 0", busy); end
  endtask

  task automatic test_empty();
    logic [8*R-1:0] b;
    b = '0; b[31:0] = 32'h0402_0001; b[8*(R-1) +: 8] = 8'h80;
    set_msg(0, 0);
    run_msg(100, 100);
    n_chk++; if (rx_q.size() !== 1) begin n_err++; $display("FAIL empty_nblk got %0d want 1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      n_chk++; if (rx_q[0] !== b || rx_lq[0] !== 1'b1) begin n_err++;
        $display("FAIL empty_block byte %0d got %h want %h last %b", diff_byte(rx_q[0], b),
                 rx_q[0][8*diff_byte(rx_q[0], b) +: 8], b[8*diff_byte(rx_q[0], b) +: 8], rx_lq[0]); end
    end
    n_chk++; if (rx_first_cyc - tx_last_cyc !== 4) begin n_err++; $display("FAIL empty_latency got %0d want 4", rx_first_cyc - tx_last_cyc); end
  endtask

  task automatic test_boundaries();
    int lens[9] = '{132, 133, 134, 135, 136, 137, 200, 271, 272};
    for (int t = 0; t < 9; t++) begin
      set_msg(lens[t], lens[t] == 136 ? 8'hA5 : -1);
      run_msg(t < 5 ? 100 : 80, t < 5 ? 100 : 70);
      n_chk++; if (tx_to || rx_to || rx_q.size() !== exp_q.size()) begin n_err++;
        $display("FAIL bnd_len%0d_nblk got %0d want %0d (timeout %0b)", lens[t], rx_q.size(), exp_q.size(), tx_to | rx_to); end
      for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++) begin
        n_chk++; if (rx_q[k] !== exp_q[k] || rx_lq[k] !== exp_lq[k]) begin n_err++;
          $display("FAIL bnd_len%0d_blk%0d byte %0d got %h want %h last %b want %b", lens[t], k,
                   diff_byte(rx_q[k], exp_q[k]), rx_q[k][8*diff_byte(rx_q[k], exp_q[k]) +: 8],
                   exp_q[k][8*diff_byte(rx_q[k], exp_q[k]) +: 8], rx_lq[k], exp_lq[k]); end
      end
      if (lens[t] == 132 && rx_q.size() > 0) begin
        n_chk++; if (rx_q[0][8*(R-1) +: 8] !== 8'h84) begin n_err++; $display("FAIL bnd_pad84 got %h want 84", rx_q[0][8*(R-1) +: 8]); end
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 300);
      set_msg(len, -1);
      run_msg(60, 50);
      n_chk++; if (tx_to || rx_to || rx_q.size() !== exp_q.size()) begin n_err++;
        $display("FAIL rnd_len%0d_nblk got %0d want %0d (timeout %0b)", len, rx_q.size(), exp_q.size(), tx_to | rx_to); end
      for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++) begin
        n_chk++; if (rx_q[k] !== exp_q[k] || rx_lq[k] !== exp_lq[k]) begin n_err++;
          $display("FAIL rnd_len%0d_blk%0d byte %0d got %h want %h last %b want %b", len, k,
                   diff_byte(rx_q[k], exp_q[k]), rx_q[k][8*diff_byte(rx_q[k], exp_q[k]) +: 8],
                   exp_q[k][8*diff_byte(rx_q[k], exp_q[k]) +: 8], rx_lq[k], exp_lq[k]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8*R-1:0] snap;
    int c;
    set_msg(136, -1);
    build_exp();
    blk_ready = 0;
    fork
      send(100);
      begin
        c = 0;
        @(negedge clk);
        while (!blk_valid && c < BUDGET) begin @(negedge clk); c++; end
        n_chk++; if (blk_valid !== 1'b1) begin n_err++; $display("FAIL bp_wait_valid got %b want 1", blk_valid); end
        snap = blk_data;
        n_chk++; if (snap !== exp_q[0] || blk_last !== 1'b0) begin n_err++;
          $display("FAIL bp_block0 byte %0d got %h want %h last %b", diff_byte(snap, exp_q[0]),
                   snap[8*diff_byte(snap, exp_q[0]) +: 8], exp_q[0][8*diff_byte(snap, exp_q[0]) +: 8], blk_last); end
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          n_chk++; if (blk_valid !== 1'b1 || msg_ready !== 1'b0 || blk_data !== snap || blk_last !== 1'b0) begin n_err++;
            $display("FAIL bp_hold cyc%0d valid %b ready %b last %b data_ok %b want 1 0 0 1", k,
                     blk_valid, msg_ready, blk_last, blk_data === snap); end
        end
        recv(100);
      end
    join
    n_chk++; if (rx_to || rx_q.size() !== 2) begin n_err++; $display("FAIL bp_nblk got %0d want 2", rx_q.size()); end
    if (rx_q.size() == 2) begin
      n_chk++; if (rx_q[1] !== exp_q[1] || rx_lq[1] !== 1'b1) begin n_err++;
        $display("FAIL bp_block1 byte %0d got %h want %h last %b", diff_byte(rx_q[1], exp_q[1]),
                 rx_q[1][8*diff_byte(rx_q[1], exp_q[1]) +: 8], exp_q[1][8*diff_byte(rx_q[1], exp_q[1]) +: 8], rx_lq[1]); end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      msg_valid = 1; msg_last = 0; msg_empty = 0; msg_data = 8'($urandom);
    end
    @(negedge clk);
    msg_valid = 0;
    n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", busy); end
    rst_n = 0;
    #1;
    n_chk++; if (msg_ready !== 0 || blk_valid !== 0 || blk_last !== 0 || busy !== 0 || blk_data !== '0) begin n_err++;
      $display("FAIL mid_reset_outs ready %b valid %b last %b busy %b data_zero %b want 0 0 0 0 1",
               msg_ready, blk_valid, blk_last, busy, blk_data === '0); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    set_msg(0, 0);
    txq = '{8'h61, 8'h62, 8'h63}; tx_empty = 0;
    run_msg(100, 100);
    n_chk++; if (rx_q.size() !== 1) begin n_err++; $display("FAIL mid_abc_nblk got %0d want 1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      n_chk++; if (rx_q[0] !== abc_block() || rx_lq[0] !== 1'b1) begin n_err++;
        $display("FAIL mid_abc_data byte %0d got %h want %h last %b", diff_byte(rx_q[0], abc_block()),
                 rx_q[0][8*diff_byte(rx_q[0], abc_block()) +: 8], abc_block()[8*diff_byte(rx_q[0], abc_block()) +: 8], rx_lq[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_boundaries();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
